// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache sequencing controller.
// Lines are 4 words; fills start at the critical word and wrap within the line.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_RD_FILL  = 3'd2,
    S_VALIDATE = 3'd3,
    S_WR_REQ   = 3'd4
  } state_e;

  localparam int WORD_ADDR_W = 32;
  localparam int LINE_WORDS  = 4;
  localparam int CNT_W       = 3;
  localparam logic [CNT_W-1:0] CNT_COMMIT = 3'd4;

  // Word k of the fill sequence: the offset advances mod 4 so the line base never changes.
  function automatic logic [WORD_ADDR_W-1:0] line_word_addr(input logic [WORD_ADDR_W-1:0] addr,
                                                             input logic [1:0] k);
    return {addr[WORD_ADDR_W-1:2], addr[1:0] + k};
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Cache controller: critical-word-first read-miss fill, write-through / no-write-allocate
// stores, single-port memory with a req/ack handshake.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = WORD_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              hit,
  output logic              cpu_stall,
  output logic              cache_read,
  output logic              cache_write,
  output logic [CNT_W-1:0]  fill_counter,
  output logic [DATA_W-1:0] fill_word,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] fill_word_q, fill_word_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  fill_counter_q, fill_counter_d;

  // Next-state logic; memory and fill outputs are computed for the state being entered.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    fill_word_d    = fill_word_q;
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    fill_counter_d = 3'd0;
    cpu_stall      = 1'b1;
    cache_read     = 1'b0;
    cache_write    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cache_read  = cpu_read & hit;
        cpu_stall   = (cpu_read & ~hit) | cpu_write;
        cache_write = cpu_write & hit;
        // A store wins over a simultaneous load; the held load is picked up on return.
        if (cpu_write) begin
          addr_d      = cpu_addr;
          wdata_d     = cpu_wdata;
          state_d     = S_WR_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end else if (cpu_read & ~hit) begin
          addr_d     = cpu_addr;
          k_d        = 2'd0;
          state_d    = S_RD_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = line_word_addr(cpu_addr, 2'd0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (mem_ack) begin
          fill_word_d    = mem_rdata;
          fill_counter_d = {1'b0, k_q};
          state_d        = S_RD_FILL;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = line_word_addr(addr_q, k_q);
        end
      end
      S_RD_FILL: begin
        cache_read = 1'b1;
        if (k_q == 2'd3) begin
          fill_counter_d = CNT_COMMIT;
          state_d        = S_VALIDATE;
        end else begin
          k_d        = k_q + 2'd1;
          state_d    = S_RD_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = line_word_addr(addr_q, k_q + 2'd1);
        end
      end
      S_VALIDATE: begin
        cache_read = 1'b1;
        k_d        = 2'd0;
        state_d    = S_IDLE;
      end
      S_WR_REQ: begin
        cpu_stall = ~mem_ack;
        if (mem_ack) begin
          state_d = S_IDLE;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops mem_req without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      k_q            <= 2'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      fill_word_q    <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      fill_counter_q <= 3'd0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      fill_word_q    <= fill_word_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      fill_counter_q <= fill_counter_d;
    end
  end

  assign fill_word    = fill_word_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign fill_counter = fill_counter_q;

endmodule
